// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB encodings and slave-4 storage defaults.
//   - HRESP and HTRANS codes
//   - slave-4 control FSM state encoding
//   - default geometry/timing constants for ahb_slave4_mem
package ahb_pkg;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    IDLE       = 1'b0,
    SPLIT_WAIT = 1'b1
  } s4_state_e;

  localparam int S4_ADDR_W     = 8;
  localparam int S4_SPLIT_BASE = 192;
  localparam int S4_SPLIT_LAT  = 4;
  localparam int S4_WP_LIMIT   = 16;

endpackage

// File: rtl/ahb_slave4_ram.sv
// ahb_slave4_ram: single-port synchronous 2^ADDR_W x 32 word array.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   async active-low reset (read register only, not the array)
//   we_i     in   write enable
//   re_i     in   read enable; rdata_o updates only when set
//   addr_i   in   word index shared by read and write
//   wdata_i  in   write data
//   rdata_o  out  registered read data, holds between reads
module ahb_slave4_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_slave4_mem.sv
// ahb_slave4_mem: slave-4 storage block behind the slave-4 interface.
// Fast region answers reads the cycle after the request; indices at or
// above SPLIT_BASE answer through split_out, then valid_aft_split_out
// SPLIT_LAT cycles later.
// Optional macro SLAVE4_WRITE_PROTECT_EN: indices below WP_LIMIT are read-only
// (writes there return error_out and leave RAM untouched).
// Ports:
//   hclk                 in   clock, rising edge
//   hresetn              in   async active-low reset
//   sel                  in   request qualifier
//   haddr_in[31:0]       in   byte address
//   hwdata_in[31:0]      in   write data
//   hwrite_in            in   1 = write, 0 = read
//   hrdata_out[31:0]     out  read data
//   split_out            out  one-cycle split request
//   error_out            out  one-cycle error response
//   valid_aft_split_out  out  one-cycle data valid after split
//   busy                 out  split read outstanding
module ahb_slave4_mem
  import ahb_pkg::*;
#(
  parameter int ADDR_W     = S4_ADDR_W,
  parameter int SPLIT_BASE = S4_SPLIT_BASE,
  parameter int SPLIT_LAT  = S4_SPLIT_LAT,
  parameter int WP_LIMIT   = S4_WP_LIMIT
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        sel,
  input  logic [31:0] haddr_in,
  input  logic [31:0] hwdata_in,
  input  logic        hwrite_in,
  output logic [31:0] hrdata_out,
  output logic        split_out,
  output logic        error_out,
  output logic        valid_aft_split_out,
  output logic        busy
);

  localparam logic [3:0] LAT_M1 = 4'(SPLIT_LAT - 1);

  s4_state_e         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx, idx_q, idx_d, ram_addr;
  logic              split_q, split_d, err_q, err_d, vld_q, vld_d;
  logic              illegal, wp_blk, slow, ram_we, ram_re;

  assign idx     = haddr_in[ADDR_W+1:2];
  assign illegal = (haddr_in[1:0] != 2'b00) || (haddr_in[31:ADDR_W+2] != '0);
  assign slow    = int'(idx) >= SPLIT_BASE;

`ifdef SLAVE4_WRITE_PROTECT_EN
  assign wp_blk = int'(idx) < WP_LIMIT;
`else
  logic unused_wp;
  assign wp_blk    = 1'b0;
  assign unused_wp = int'(idx) < WP_LIMIT;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    split_d  = 1'b0;
    err_d    = 1'b0;
    vld_d    = 1'b0;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = idx;
    case (state_q)
      IDLE: begin
        if (sel) begin
          if (illegal || (hwrite_in && wp_blk)) begin
            err_d = 1'b1;
          end else if (hwrite_in) begin
            ram_we = 1'b1;
          end else if (slow) begin
            split_d = 1'b1;
            idx_d   = idx;
            cnt_d   = LAT_M1;
            state_d = SPLIT_WAIT;
          end else begin
            ram_re = 1'b1;
          end
        end
      end
      SPLIT_WAIT: begin
        // sel is ignored here; the RAM port belongs to the pending read.
        ram_addr = idx_q;
        if (cnt_q == 4'd0) begin
          ram_re  = 1'b1;
          vld_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      split_q <= split_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
    end
  end

  ahb_slave4_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk_i   (hclk),
    .rst_ni  (hresetn),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (hwdata_in),
    .rdata_o (hrdata_out)
  );

  assign split_out           = split_q;
  assign error_out           = err_q;
  assign valid_aft_split_out = vld_q;
  assign busy                = (state_q == SPLIT_WAIT);

endmodule

// File: tb/tb_ahb_slave4_mem.sv
module tb_ahb_slave4_mem;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        sel;
  logic [31:0] haddr_in;
  logic [31:0] hwdata_in;
  logic        hwrite_in;
  logic [31:0] hrdata_out;
  logic        split_out, error_out, valid_aft_split_out, busy;

  int errors = 0;
  int checks = 0;

  always #5 hclk = ~hclk;

  ahb_slave4_mem dut (
    .hclk                (hclk),
    .hresetn             (hresetn),
    .sel                 (sel),
    .haddr_in            (haddr_in),
    .hwdata_in           (hwdata_in),
    .hwrite_in           (hwrite_in),
    .hrdata_out          (hrdata_out),
    .split_out           (split_out),
    .error_out           (error_out),
    .valid_aft_split_out (valid_aft_split_out),
    .busy                (busy)
  );

  // {split, error, valid_aft_split, busy}
  wire [3:0] flags = {split_out, error_out, valid_aft_split_out, busy};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    sel = 1'b1; hwrite_in = 1'b1; haddr_in = a; hwdata_in = d;
    tick();
    sel = 1'b0; hwrite_in = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    sel = 1'b1; hwrite_in = 1'b0; haddr_in = a;
    tick();
    sel = 1'b0;
  endtask

  initial begin
    logic seen_vld;
    hresetn = 1'b0; sel = 1'b0; haddr_in = '0; hwdata_in = '0; hwrite_in = 1'b0;
    tick(); tick();
    check("reset_hrdata", hrdata_out, 32'h0);
    check("reset_flags", {28'h0, flags}, 32'h0);
    hresetn = 1'b1;
    tick();

    // fast write then read
    wr(32'h40, 32'hDEADBEEF);
    check("wr40_flags", {28'h0, flags}, 32'h0);
    check("wr40_hrdata_hold", hrdata_out, 32'h0);
    rd(32'h40);
    check("rd40_data", hrdata_out, 32'hDEADBEEF);
    check("rd40_flags", {28'h0, flags}, 32'h0);
    tick();
    check("rd40_hold", hrdata_out, 32'hDEADBEEF);

    // back-to-back write/read same index
    wr(32'h44, 32'h0BADF00D);
    rd(32'h44);
    check("rd44_data", hrdata_out, 32'h0BADF00D);

    // async reset mid-cycle clears outputs immediately
    #3 hresetn = 1'b0;
    #1;
    check("async_rst_hrdata", hrdata_out, 32'h0);
    check("async_rst_flags", {28'h0, flags}, 32'h0);
    tick();
    hresetn = 1'b1;
    tick();

    // split read with ignored requests during the wait
    wr(32'h300, 32'h12345678);
    rd(32'h44);
    check("rd44_after_rst", hrdata_out, 32'h0BADF00D);
    rd(32'h300);
    check("split_flags_e0", {28'h0, flags}, 32'h9);
    check("split_hold_e0", hrdata_out, 32'h0BADF00D);
    rd(32'h40);
    check("split_flags_e1", {28'h0, flags}, 32'h1);
    check("split_hold_e1", hrdata_out, 32'h0BADF00D);
    wr(32'h40, 32'h55555555);
    check("split_flags_e2", {28'h0, flags}, 32'h1);
    tick();
    check("split_flags_e3", {28'h0, flags}, 32'h1);
    check("split_hold_e3", hrdata_out, 32'h0BADF00D);
    tick();
    check("split_flags_e4", {28'h0, flags}, 32'h2);
    check("split_data_e4", hrdata_out, 32'h12345678);
    // request in the valid cycle is accepted; also shows 0x40 was not overwritten
    rd(32'h40);
    check("rd40_in_vld_cycle", hrdata_out, 32'hDEADBEEF);
    check("rd40_in_vld_flags", {28'h0, flags}, 32'h0);

    // errors
    rd(32'h42);
    check("misalign_flags", {28'h0, flags}, 32'h4);
    check("misalign_hold", hrdata_out, 32'hDEADBEEF);
    tick();
    check("misalign_clear", {28'h0, flags}, 32'h0);
`ifndef SLAVE4_WRITE_PROTECT_EN
    wr(32'h0, 32'h00C0FFEE);
`endif
    wr(32'h400, 32'hFFFFFFFF);
    check("oor_wr_flags", {28'h0, flags}, 32'h4);
    wr(32'h440, 32'hFFFFFFFF);
    check("oor_wr2_flags", {28'h0, flags}, 32'h4);
    rd(32'h40);
    check("oor_alias40", hrdata_out, 32'hDEADBEEF);
`ifndef SLAVE4_WRITE_PROTECT_EN
    rd(32'h0);
    check("oor_alias0", hrdata_out, 32'h00C0FFEE);
`endif

    // write protect region
    wr(32'h10, 32'hAAAA5555);
`ifdef SLAVE4_WRITE_PROTECT_EN
    check("wp_wr_flags", {28'h0, flags}, 32'h4);
    rd(32'h10);
    checks++;
    assert (hrdata_out !== 32'hAAAA5555) else begin
      errors++;
      $error("FAIL wp_rd: observed=%h expected other than %h", hrdata_out, 32'hAAAA5555);
    end
`else
    check("wp_wr_flags", {28'h0, flags}, 32'h0);
    rd(32'h10);
    check("wp_rd", hrdata_out, 32'hAAAA5555);
`endif

    // reset two cycles after split abandons the read
    rd(32'h300);
    check("split2_flags", {28'h0, flags}, 32'h9);
    tick(); tick();
    #2 hresetn = 1'b0;
    #1;
    check("midsplit_rst_flags", {28'h0, flags}, 32'h0);
    check("midsplit_rst_hrdata", hrdata_out, 32'h0);
    tick();
    #3 hresetn = 1'b1;
    seen_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid_aft_split_out || busy) seen_vld = 1'b1;
    end
    check("no_vld_after_rst", {31'h0, seen_vld}, 32'h0);
    rd(32'h40);
    check("post_rst_rd40", hrdata_out, 32'hDEADBEEF);
    check("post_rst_flags", {28'h0, flags}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
